fp_int_mac_operand_sequencer: RTL and testbench

Upstream feeder for `fp_int_mac_bit_serial`. Buffers a group of FP16 activations with their integer weights and computes the group's minimum exponent. It pulses `set` with that exponent, then replays each activation while streaming its weight bit-serially, MSB first, at the programmed precision. It then waits for the MAC's `done` and reports group completion.

---
 rtl/fp_int_mac_pkg.sv | 17 +
 rtl/fp16_exp_min_tracker.sv | 24 ++
 rtl/fp_int_mac_operand_sequencer.sv | 153 +++++++++++++++
 tb/tb_fp_int_mac_operand_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_int_mac_pkg.sv
// Shared types and FP16 field constants for the bit-serial MAC operand path.
package fp_int_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SET,
    ST_ISSUE,
    ST_GAP,
    ST_DRAIN
  } state_e;

  localparam int EXP_LSB  = 10;
  localparam int EXP_MSB  = 14;
  localparam int PREC_MIN = 2;

endpackage

// File: rtl/fp16_exp_min_tracker.sv
// Running minimum of FP16 exponents over a group; zero/subnormal exponents are skipped.
module fp16_exp_min_tracker #(
  parameter int EXP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 update,
  input  logic [EXP_WIDTH-1:0] exp_in,
  output logic [EXP_WIDTH-1:0] value
);

  // A value of 0 doubles as "nothing included yet", since included exponents are >= 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (init) begin
      value <= exp_in;
    end else if (update && (exp_in != '0) && ((value == '0) || (exp_in < value))) begin
      value <= exp_in;
    end
  end

endmodule

// File: rtl/fp_int_mac_operand_sequencer.sv
// Buffers a group of FP16 activations + weights, then replays them to the bit-serial MAC.
module fp_int_mac_operand_sequencer
  import fp_int_mac_pkg::*;
#(
  parameter int GROUP     = 8,
  parameter int ACT_WIDTH = 16,
  parameter int W_MAX     = 8,
  parameter int EXP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [W_MAX-1:0]     in_w,
  input  logic [3:0]           precision,
  output logic                 mac_set,
  output logic [EXP_WIDTH-1:0] mac_exp_min,
  output logic [ACT_WIDTH-1:0] mac_act,
  output logic                 mac_valid,
  output logic                 mac_w,
  output logic [3:0]           mac_precision,
  input  logic                 mac_done,
  output logic                 group_done,
  output logic                 busy
);

  localparam int IDX_W = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GROUP - 1);

  typedef struct packed {
    logic [ACT_WIDTH-1:0] act;
    logic [W_MAX-1:0]     w;
  } entry_t;

  function automatic logic [3:0] clamp_precision(input logic [3:0] p);
    if (p < 4'(PREC_MIN)) return 4'(PREC_MIN);
    if (p > 4'(W_MAX))    return 4'(W_MAX);
    return p;
  endfunction

  state_e           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, wr_idx;
  logic [3:0]       bitc, bit_nxt;
  entry_t           op_buf [GROUP];
  entry_t           sel;
  logic [W_MAX-1:0] w_shift;
  logic             accept;

  logic                 mac_set_d, mac_valid_d, mac_w_d, group_done_d;
  logic [ACT_WIDTH-1:0] mac_act_d;
  logic [3:0]           precision_d;

  assign in_ready = ((state == ST_IDLE) || (state == ST_LOAD)) && !group_done;
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign wr_idx   = (state == ST_IDLE) ? '0 : idx;

  fp16_exp_min_tracker #(.EXP_WIDTH(EXP_WIDTH)) u_exp_min (
    .clk    (clk),
    .rst    (rst),
    .init   (accept && (state == ST_IDLE)),
    .update (accept && (state == ST_LOAD)),
    .exp_in (in_act[EXP_MSB:EXP_LSB]),
    .value  (mac_exp_min)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      bitc  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      bitc  <= bit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bit_nxt   = bitc;
    case (state)
      ST_IDLE: if (accept) begin
        state_nxt = ST_LOAD;
        idx_nxt   = IDX_W'(1);
      end
      ST_LOAD: if (accept) begin
        if (idx == IDX_LAST) begin
          state_nxt = ST_SET;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_SET: begin
        state_nxt = ST_ISSUE;
        idx_nxt   = '0;
        bit_nxt   = '0;
      end
      ST_ISSUE: begin
        if (bitc == mac_precision - 4'd1) begin
          state_nxt = (idx == IDX_LAST) ? ST_DRAIN : ST_GAP;
        end else begin
          bit_nxt = bitc + 4'd1;
        end
      end
      ST_GAP: begin
        state_nxt = ST_ISSUE;
        idx_nxt   = idx + IDX_W'(1);
        bit_nxt   = '0;
      end
      ST_DRAIN: if (mac_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state and counters, then registered.
  always_comb begin
    sel          = op_buf[idx_nxt];
    w_shift      = sel.w >> (mac_precision - 4'd1 - bit_nxt);
    mac_set_d    = (state_nxt == ST_SET);
    mac_valid_d  = (state_nxt == ST_ISSUE);
    mac_w_d      = mac_valid_d && w_shift[0];
    mac_act_d    = mac_valid_d ? sel.act : mac_act;
    group_done_d = (state == ST_DRAIN) && mac_done;
    precision_d  = (accept && (state == ST_IDLE)) ? clamp_precision(precision) : mac_precision;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_set       <= 1'b0;
      mac_valid     <= 1'b0;
      mac_w         <= 1'b0;
      mac_act       <= '0;
      group_done    <= 1'b0;
      mac_precision <= 4'(PREC_MIN);
    end else begin
      mac_set       <= mac_set_d;
      mac_valid     <= mac_valid_d;
      mac_w         <= mac_w_d;
      mac_act       <= mac_act_d;
      group_done    <= group_done_d;
      mac_precision <= precision_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) op_buf[wr_idx] <= '{act: in_act, w: in_w};
  end

endmodule

// File: tb/tb_fp_int_mac_operand_sequencer.sv
// Directed bench for the operand sequencer with GROUP=4.
module tb_fp_int_mac_operand_sequencer;

  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_act = '0;
  logic [7:0]  in_w = '0;
  logic [3:0]  precision = '0;
  logic        mac_set;
  logic [4:0]  mac_exp_min;
  logic [15:0] mac_act;
  logic        mac_valid;
  logic        mac_w;
  logic [3:0]  mac_precision;
  logic        mac_done = 1'b0;
  logic        group_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_int_mac_operand_sequencer #(.GROUP(G), .ACT_WIDTH(16), .W_MAX(8), .EXP_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .in_w(in_w), .precision(precision), .mac_set(mac_set), .mac_exp_min(mac_exp_min),
    .mac_act(mac_act), .mac_valid(mac_valid), .mac_w(mac_w), .mac_precision(mac_precision),
    .mac_done(mac_done), .group_done(group_done), .busy(busy)
  );

  typedef struct packed {
    logic [3:0][15:0] act;
    logic [3:0][7:0]  w;
    logic [3:0]       prec;
    logic [4:0]       exp_min;
    logic [3:0]       exp_prec;
    logic [31:0]      stream;
    int               nvalid;
    bit               stress;
  } vec_t;

  vec_t vecs[4];

  function automatic vec_t mk(input logic [15:0] a0, a1, a2, a3, input logic [7:0] w0, w1, w2, w3,
                              input logic [3:0] p, input logic [4:0] e, input logic [3:0] ep,
                              input logic [31:0] s, input int n, input bit st);
    vec_t v;
    v.act[0] = a0; v.act[1] = a1; v.act[2] = a2; v.act[3] = a3;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.prec = p; v.exp_min = e; v.exp_prec = ep; v.stream = s; v.nvalid = n; v.stress = st;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic load_group(input vec_t v);
    for (int i = 0; i < G; i++) begin
      in_valid  = 1'b1;
      in_act    = v.act[i];
      in_w      = v.w[i];
      precision = v.prec;
      if (i == 0) check("in_ready_before_load", {31'b0, in_ready}, 32'd1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    logic [31:0] got_stream;
    int nvalid, first_k, last_k, elem, act_err, exp_err, gd_seen, ready_seen;
    bit prev_valid;
    got_stream = '0; nvalid = 0; first_k = -1; last_k = -1; elem = 0;
    act_err = 0; exp_err = 0; gd_seen = 0; ready_seen = 0; prev_valid = 1'b0;
    load_group(v);
    check($sformatf("v%0d_set", n), {31'b0, mac_set}, 32'd1);
    check($sformatf("v%0d_exp_min", n), {27'b0, mac_exp_min}, {27'b0, v.exp_min});
    check($sformatf("v%0d_precision", n), {28'b0, mac_precision}, {28'b0, v.exp_prec});
    check($sformatf("v%0d_ready_in_set", n), {31'b0, in_ready}, 32'd0);
    if (v.stress) begin
      in_valid = 1'b1; in_act = 16'h7BFF; in_w = 8'hFF; mac_done = 1'b1;
    end
    step();
    check($sformatf("v%0d_set_one_cycle", n), {31'b0, mac_set}, 32'd0);
    for (int k = 0; k < v.nvalid + (G - 1) + 4; k++) begin
      if (mac_valid) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        nvalid++;
        got_stream = {got_stream[30:0], mac_w};
        if (elem < G && mac_act !== v.act[elem]) act_err++;
      end else if (prev_valid) begin
        elem++;
      end
      prev_valid = mac_valid;
      if (mac_exp_min !== v.exp_min) exp_err++;
      if (group_done) gd_seen++;
      if (in_ready) ready_seen++;
      if (k == 5) mac_done = 1'b0;
      step();
    end
    in_valid = 1'b0;
    mac_done = 1'b0;
    check($sformatf("v%0d_first_valid_after_set", n), first_k, 0);
    check($sformatf("v%0d_valid_count", n), nvalid, v.nvalid);
    check($sformatf("v%0d_span", n), last_k - first_k + 1, v.nvalid + G - 1);
    check($sformatf("v%0d_stream", n), got_stream, v.stream);
    check($sformatf("v%0d_act_per_element", n), act_err, 0);
    check($sformatf("v%0d_exp_min_held", n), exp_err, 0);
    check($sformatf("v%0d_no_early_group_done", n), gd_seen, 0);
    check($sformatf("v%0d_not_ready_while_busy", n), ready_seen, 0);
    check($sformatf("v%0d_drain_valid", n), {31'b0, mac_valid}, 32'd0);
    check($sformatf("v%0d_drain_busy", n), {31'b0, busy}, 32'd1);
    mac_done = 1'b1;
    step();
    mac_done = 1'b0;
    check($sformatf("v%0d_group_done", n), {31'b0, group_done}, 32'd1);
    check($sformatf("v%0d_exp_at_done", n), {27'b0, mac_exp_min}, {27'b0, v.exp_min});
    check($sformatf("v%0d_idle_busy", n), {31'b0, busy}, 32'd0);
    step();
    check($sformatf("v%0d_group_done_pulse", n), {31'b0, group_done}, 32'd0);
    check($sformatf("v%0d_ready_after_done", n), {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int gd_after_rst;
    vecs[0] = mk(16'h4569, 16'h4AAA, 16'hBE80, 16'h4AAA, 8'h0A, 8'h07, 8'h08, 8'h01,
                 4'd4, 5'd15, 4'd4, 32'h0000A781, 16, 1'b1);
    vecs[1] = mk(16'h0000, 16'h4569, 16'h8000, 16'h0001, 8'hA5, 8'h3C, 8'h81, 8'h7E,
                 4'd12, 5'd17, 4'd8, 32'hA53C817E, 32, 1'b0);
    vecs[2] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'hF2, 8'h01, 8'hFF, 8'h00,
                 4'd0, 5'd0, 4'd2, 32'h0000009C, 8, 1'b0);
    vecs[3] = mk(16'h7C00, 16'h7FFF, 16'hFC00, 16'h7C01, 8'h05, 8'h02, 8'h07, 8'h04,
                 4'd3, 5'd31, 4'd3, 32'h00000ABC, 12, 1'b0);

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mac_set", {31'b0, mac_set}, 32'd0);
    check("rst_mac_valid", {31'b0, mac_valid}, 32'd0);
    check("rst_mac_w", {31'b0, mac_w}, 32'd0);
    check("rst_group_done", {31'b0, group_done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_exp_min", {27'b0, mac_exp_min}, 32'd0);
    check("rst_mac_act", {16'b0, mac_act}, 32'd0);
    check("rst_precision", {28'b0, mac_precision}, 32'd2);

    for (int n = 0; n < 4; n++) run_vec(n, vecs[n]);

    // Abort mid-issue on the third element, then confirm no completion leaks out.
    load_group(vecs[0]);
    step();
    for (int k = 0; k < 2 * (4 + 1); k++) step();
    check("abort_third_elem_issuing", {31'b0, mac_valid}, 32'd1);
    check("abort_third_elem_act", {16'b0, mac_act}, {16'b0, vecs[0].act[2]});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", {31'b0, mac_valid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_precision", {28'b0, mac_precision}, 32'd2);
    gd_after_rst = 0;
    mac_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (group_done) gd_after_rst++;
    end
    mac_done = 1'b0;
    check("abort_no_group_done", gd_after_rst, 0);
    step();

    run_vec(4, vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
